// File: rtl/frame_sequencer.sv
// Frame sequencer: streams voxels to the rasterizer array, steps palette ids through the
// shaders, then reads every shader pixel back and writes it to the frame buffer.
module frame_sequencer #(
    parameter int COORD_BITS   = 8,
    parameter int PALETTE_BITS = 8,
    parameter int PIXEL_BITS   = 8,
    parameter int VADDR_BITS   = 10,
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int ROW_BITS     = 8,
    parameter int COL_BITS     = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [VADDR_BITS-1:0]                voxel_count,
    output logic [VADDR_BITS-1:0]                vox_addr,
    input  logic [3*COORD_BITS+PALETTE_BITS-1:0] vox_rdata,
    output logic [PALETTE_BITS-1:0]              pal_addr,
    input  logic [PIXEL_BITS-1:0]                pal_rdata,
    output logic                                 do_rasterize,
    output logic                                 do_shade,
    output logic [COORD_BITS-1:0]                voxel_x,
    output logic [COORD_BITS-1:0]                voxel_y,
    output logic [COORD_BITS-1:0]                voxel_z,
    output logic [PALETTE_BITS-1:0]              voxel_id,
    output logic [PIXEL_BITS-1:0]                palette_entry,
    input  logic                                 rasterizing_done,
    input  logic                                 shading_done,
    output logic [ROW_BITS-1:0]                  row,
    output logic [COL_BITS-1:0]                  col,
    input  logic [PIXEL_BITS-1:0]                pixel,
    output logic                                 fb_we,
    output logic [ROW_BITS+COL_BITS-1:0]         fb_addr,
    output logic [PIXEL_BITS-1:0]                fb_data,
    input  logic                                 fb_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int VOX_BITS = 3*COORD_BITS + PALETTE_BITS;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        RASTER,
        SHADE,
        READOUT,
        READ_WAIT,
        WRITE,
        FINISH
    } state_t;

    state_t                  state_reg;
    logic [VADDR_BITS-1:0]   vox_index_reg;
    logic [VADDR_BITS-1:0]   count_reg;
    logic                    phase_reg;
    logic                    shade_setup_reg;

    // Unpacked {x,y,z} fields of the voxel word, x in the most significant slice.
    logic [COORD_BITS-1:0]   coord [3];
    logic [PALETTE_BITS-1:0] rd_id;

    for (genvar gi = 0; gi < 3; gi++) begin : g_coord
        assign coord[gi] = vox_rdata[VOX_BITS-1-gi*COORD_BITS -: COORD_BITS];
    end
    assign rd_id = vox_rdata[PALETTE_BITS-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            vox_index_reg   <= '0;
            count_reg       <= '0;
            phase_reg       <= 1'b0;
            shade_setup_reg <= 1'b0;
            vox_addr        <= '0;
            pal_addr        <= '0;
            do_rasterize    <= 1'b0;
            do_shade        <= 1'b0;
            voxel_x         <= '0;
            voxel_y         <= '0;
            voxel_z         <= '0;
            voxel_id        <= '0;
            palette_entry   <= '0;
            row             <= '0;
            col             <= '0;
            fb_we           <= 1'b0;
            fb_addr         <= '0;
            fb_data         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= PREFETCH;
                        busy          <= 1'b1;
                        vox_addr      <= '0;
                        vox_index_reg <= '0;
                        count_reg     <= voxel_count;
                        phase_reg     <= 1'b0;
                    end
                end

                PREFETCH: begin
                    if (!phase_reg) begin
                        if (count_reg == '0) begin
                            // Nothing to rasterize: go straight to palette setup.
                            state_reg       <= SHADE;
                            shade_setup_reg <= 1'b1;
                            pal_addr        <= '0;
                        end else begin
                            vox_addr  <= VADDR_BITS'(1);
                            phase_reg <= 1'b1;
                        end
                    end else begin
                        voxel_x      <= coord[0];
                        voxel_y      <= coord[1];
                        voxel_z      <= coord[2];
                        voxel_id     <= rd_id;
                        do_rasterize <= 1'b1;
                        phase_reg    <= 1'b0;
                        state_reg    <= RASTER;
                    end
                end

                RASTER: begin
                    if (rasterizing_done) begin
                        if (vox_index_reg == count_reg - VADDR_BITS'(1)) begin
                            do_rasterize    <= 1'b0;
                            state_reg       <= SHADE;
                            shade_setup_reg <= 1'b1;
                            phase_reg       <= 1'b0;
                            pal_addr        <= '0;
                        end else begin
                            // vox_rdata already holds voxel i+1; start fetching i+2.
                            voxel_x       <= coord[0];
                            voxel_y       <= coord[1];
                            voxel_z       <= coord[2];
                            voxel_id      <= rd_id;
                            vox_index_reg <= vox_index_reg + VADDR_BITS'(1);
                            vox_addr      <= vox_index_reg + VADDR_BITS'(2);
                        end
                    end
                end

                SHADE: begin
                    if (shade_setup_reg) begin
                        if (!phase_reg) begin
                            pal_addr  <= PALETTE_BITS'(1);
                            phase_reg <= 1'b1;
                        end else begin
                            palette_entry   <= pal_rdata;
                            voxel_id        <= '0;
                            do_shade        <= 1'b1;
                            shade_setup_reg <= 1'b0;
                            phase_reg       <= 1'b0;
                        end
                    end else if (shading_done) begin
                        // Stop on the last id instead of letting the counter wrap.
                        if (voxel_id == '1) begin
                            do_shade  <= 1'b0;
                            pal_addr  <= '0;
                            row       <= '0;
                            col       <= '0;
                            state_reg <= READOUT;
                        end else begin
                            voxel_id      <= voxel_id + PALETTE_BITS'(1);
                            palette_entry <= pal_rdata;
                            pal_addr      <= voxel_id + PALETTE_BITS'(2);
                        end
                    end
                end

                READOUT: begin
                    state_reg <= READ_WAIT;
                end

                READ_WAIT: begin
                    fb_we     <= 1'b1;
                    fb_addr   <= {row, col};
                    fb_data   <= pixel;
                    state_reg <= WRITE;
                end

                WRITE: begin
                    if (fb_ready) begin
                        fb_we   <= 1'b0;
                        fb_addr <= '0;
                        fb_data <= '0;
                        if (col == COL_BITS'(COLS-1)) begin
                            col <= '0;
                            if (row == ROW_BITS'(ROWS-1)) begin
                                row       <= '0;
                                done      <= 1'b1;
                                state_reg <= FINISH;
                            end else begin
                                row       <= row + ROW_BITS'(1);
                                state_reg <= READOUT;
                            end
                        end else begin
                            col       <= col + COL_BITS'(1);
                            state_reg <= READOUT;
                        end
                    end
                end

                FINISH: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: small 2x2 array, 2-bit palette, synchronous
// voxel/palette memories and scripted shader/frame-buffer responders.
module tb_frame_sequencer;

    localparam int COORD_BITS   = 8;
    localparam int PALETTE_BITS = 2;
    localparam int PIXEL_BITS   = 8;
    localparam int VADDR_BITS   = 10;
    localparam int ROWS         = 2;
    localparam int COLS         = 2;
    localparam int ROW_BITS     = 8;
    localparam int COL_BITS     = 8;
    localparam int VOX_BITS     = 3*COORD_BITS + PALETTE_BITS;

    logic                             clock = 1'b0;
    logic                             reset = 1'b1;
    logic                             start = 1'b0;
    logic [VADDR_BITS-1:0]            voxel_count = '0;
    logic [VADDR_BITS-1:0]            vox_addr;
    logic [VOX_BITS-1:0]              vox_rdata = '0;
    logic [PALETTE_BITS-1:0]          pal_addr;
    logic [PIXEL_BITS-1:0]            pal_rdata = '0;
    logic                             do_rasterize;
    logic                             do_shade;
    logic [COORD_BITS-1:0]            voxel_x;
    logic [COORD_BITS-1:0]            voxel_y;
    logic [COORD_BITS-1:0]            voxel_z;
    logic [PALETTE_BITS-1:0]          voxel_id;
    logic [PIXEL_BITS-1:0]            palette_entry;
    logic                             rasterizing_done = 1'b0;
    logic                             shading_done = 1'b0;
    logic [ROW_BITS-1:0]              row;
    logic [COL_BITS-1:0]              col;
    logic [PIXEL_BITS-1:0]            pixel;
    logic                             fb_we;
    logic [ROW_BITS+COL_BITS-1:0]     fb_addr;
    logic [PIXEL_BITS-1:0]            fb_data;
    logic                             fb_ready = 1'b0;
    logic                             busy;
    logic                             done;

    int checks   = 0;
    int failures = 0;

    frame_sequencer #(
        .COORD_BITS(COORD_BITS), .PALETTE_BITS(PALETTE_BITS), .PIXEL_BITS(PIXEL_BITS),
        .VADDR_BITS(VADDR_BITS), .ROWS(ROWS), .COLS(COLS),
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .voxel_count(voxel_count),
        .vox_addr(vox_addr), .vox_rdata(vox_rdata), .pal_addr(pal_addr), .pal_rdata(pal_rdata),
        .do_rasterize(do_rasterize), .do_shade(do_shade),
        .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
        .palette_entry(palette_entry), .rasterizing_done(rasterizing_done),
        .shading_done(shading_done), .row(row), .col(col), .pixel(pixel),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Voxel ids 5,7,2 live in a 2-bit id field here, so they are stored as 1,3,2.
    logic [VOX_BITS-1:0]   vmem [3];
    logic [PIXEL_BITS-1:0] pmem [4];
    initial begin
        vmem[0] = {8'd1, 8'd2, 8'd3, 2'd1};
        vmem[1] = {8'd4, 8'd4, 8'd4, 2'd3};
        vmem[2] = {8'd0, 8'd0, 8'd9, 2'd2};
        pmem[0] = 8'd10;
        pmem[1] = 8'd20;
        pmem[2] = 8'd30;
        pmem[3] = 8'd40;
    end

    always @(posedge clock) begin
        vox_rdata <= (vox_addr < 3) ? vmem[vox_addr[1:0]] : '0;
        pal_rdata <= pmem[pal_addr];
    end

    assign pixel = PIXEL_BITS'(row * 16 + col);

    // Rasterizers finish 9 cycles after each voxel is presented.
    int rast_cnt = 0;
    always @(negedge clock) begin
        if (reset || !do_rasterize) begin
            rast_cnt = 0;
            rasterizing_done = 1'b0;
        end else begin
            rast_cnt++;
            if (rast_cnt == 9) begin
                rasterizing_done = 1'b1;
                rast_cnt = 0;
            end else begin
                rasterizing_done = 1'b0;
            end
        end
    end

    // Shaders finish every second cycle while do_shade is high.
    int shade_cnt = 0;
    always @(negedge clock) begin
        if (reset || !do_shade) begin
            shade_cnt = 0;
            shading_done = 1'b0;
        end else begin
            shade_cnt++;
            shading_done = (shade_cnt % 2 == 0);
        end
    end

    // Frame buffer stalls the write to address 0 for 3 cycles, accepts others at once.
    int we_cycles = 0;
    always @(negedge clock) begin
        if (reset || !fb_we) begin
            we_cycles = 0;
            fb_ready = 1'b0;
        end else begin
            we_cycles++;
            fb_ready = (fb_addr != '0) || (we_cycles >= 4);
        end
    end

    logic [ROW_BITS+COL_BITS-1:0] commit_addr_q [$];
    logic [PIXEL_BITS-1:0]        commit_data_q [$];
    int                           commit_len_q  [$];
    always @(posedge clock) begin
        if (!reset && fb_we && fb_ready) begin
            commit_addr_q.push_back(fb_addr);
            commit_data_q.push_back(fb_data);
            commit_len_q.push_back(we_cycles);
            $display("write addr=%h data=%0d held=%0d", fb_addr, fb_data, we_cycles);
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        voxel_count = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({do_rasterize, do_shade, fb_we, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {do_rasterize, do_shade, fb_we, busy, done});
        end
        checks++;
        if ({vox_addr, pal_addr, fb_addr} !== '0) begin
            failures++;
            $display("FAIL reset_addr: got %h/%h/%h expected 0", vox_addr, pal_addr, fb_addr);
        end
        checks++;
        if ({voxel_x, voxel_y, voxel_z, voxel_id, palette_entry} !== '0) begin
            failures++;
            $display("FAIL reset_voxel: got %h expected 0", {voxel_x, voxel_y, voxel_z, voxel_id, palette_entry});
        end
        checks++;
        if ({row, col, fb_data} !== '0) begin
            failures++;
            $display("FAIL reset_readout: got %h expected 0", {row, col, fb_data});
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({busy, fb_we} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release: busy/fb_we got %b expected 00", {busy, fb_we});
        end
    endtask

    task automatic test_full_frame(input string tag);
        logic [VOX_BITS-1:0]              exp_vox [3];
        logic [PALETTE_BITS+PIXEL_BITS-1:0] exp_sh [4];
        logic [ROW_BITS+COL_BITS-1:0]     exp_addr [4];
        logic [PIXEL_BITS-1:0]            exp_data [4];
        logic [VOX_BITS-1:0]              seen_vox [$];
        logic [PALETTE_BITS+PIXEL_BITS-1:0] seen_sh [$];
        logic [VOX_BITS-1:0]              cur;
        logic [PALETTE_BITS+PIXEL_BITS-1:0] pair;
        int base, cycles, extra, rast_cycles, shade_cycles, drops, bad_changes, done_samples;
        logic prev_dr, prev_ds, finished, injected, hold_ok;
        exp_vox[0] = {8'd1, 8'd2, 8'd3, 2'd1};
        exp_vox[1] = {8'd4, 8'd4, 8'd4, 2'd3};
        exp_vox[2] = {8'd0, 8'd0, 8'd9, 2'd2};
        exp_sh[0] = {2'd0, 8'd10};
        exp_sh[1] = {2'd1, 8'd20};
        exp_sh[2] = {2'd2, 8'd30};
        exp_sh[3] = {2'd3, 8'd40};
        exp_addr[0] = 16'h0000; exp_data[0] = 8'd0;
        exp_addr[1] = 16'h0001; exp_data[1] = 8'd1;
        exp_addr[2] = 16'h0100; exp_data[2] = 8'd16;
        exp_addr[3] = 16'h0101; exp_data[3] = 8'd17;
        cycles = 0; extra = 0; rast_cycles = 0; shade_cycles = 0;
        drops = 0; bad_changes = 0; done_samples = 0;
        prev_dr = 1'b0; prev_ds = 1'b0; finished = 1'b0; injected = 1'b0; hold_ok = 1'b1;
        voxel_count = 10'd3;
        base = commit_addr_q.size();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (extra < 8 && cycles < 400) begin
            cur = {voxel_x, voxel_y, voxel_z, voxel_id};
            if (do_rasterize) begin
                rast_cycles++;
                if (seen_vox.size() == 0 || cur != seen_vox[$]) begin
                    if (seen_vox.size() != 0 && !rasterizing_done) bad_changes++;
                    seen_vox.push_back(cur);
                end
            end
            if (prev_dr && !do_rasterize) begin
                drops++;
                if (cur != exp_vox[2]) hold_ok = 1'b0;
            end
            if (do_shade) begin
                shade_cycles++;
                pair = {voxel_id, palette_entry};
                if (seen_sh.size() == 0 || pair != seen_sh[$]) seen_sh.push_back(pair);
            end
            // A start pulse in the first readout cycle must be ignored.
            if (prev_ds && !do_shade && !injected) begin
                start = 1'b1;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_samples++;
                finished = 1'b1;
            end
            if (finished) extra++;
            prev_dr = do_rasterize;
            prev_ds = do_shade;
            @(posedge clock); #1;
            cycles++;
        end
        start = 1'b0;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s_timeout: got no done in %0d cycles required done", tag, cycles);
        end
        checks++;
        if (seen_vox.size() != 3) begin
            failures++;
            $display("FAIL %s_voxel_count: got %0d voxels required 3", tag, seen_vox.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < seen_vox.size()) begin
                checks++;
                if (seen_vox[i] !== exp_vox[i]) begin
                    failures++;
                    $display("FAIL %s_voxel%0d: got %h required %h", tag, i, seen_vox[i], exp_vox[i]);
                end
            end
        end
        checks++;
        if (bad_changes != 0) begin
            failures++;
            $display("FAIL %s_voxel_change: got %0d changes without done required 0", tag, bad_changes);
        end
        checks++;
        if (drops != 1 || !hold_ok) begin
            failures++;
            $display("FAIL %s_raster_drop: got drops=%0d hold=%0d required drops=1 hold=1", tag, drops, hold_ok);
        end
        checks++;
        if (rast_cycles != 27) begin
            failures++;
            $display("FAIL %s_raster_cycles: got %0d required 27", tag, rast_cycles);
        end
        checks++;
        if (seen_sh.size() != 4) begin
            failures++;
            $display("FAIL %s_shade_count: got %0d ids required 4", tag, seen_sh.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < seen_sh.size()) begin
                checks++;
                if (seen_sh[i] !== exp_sh[i]) begin
                    failures++;
                    $display("FAIL %s_shade%0d: got %h required %h", tag, i, seen_sh[i], exp_sh[i]);
                end
            end
        end
        checks++;
        if (shade_cycles != 8) begin
            failures++;
            $display("FAIL %s_shade_cycles: got %0d required 8", tag, shade_cycles);
        end
        checks++;
        if (commit_addr_q.size() - base != 4) begin
            failures++;
            $display("FAIL %s_write_count: got %0d required 4", tag, commit_addr_q.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            if (base + i < commit_addr_q.size()) begin
                checks++;
                if (commit_addr_q[base+i] !== exp_addr[i] || commit_data_q[base+i] !== exp_data[i]) begin
                    failures++;
                    $display("FAIL %s_write%0d: got addr=%h data=%0d required addr=%h data=%0d",
                             tag, i, commit_addr_q[base+i], commit_data_q[base+i], exp_addr[i], exp_data[i]);
                end
            end
        end
        if (base < commit_len_q.size()) begin
            checks++;
            if (commit_len_q[base] != 4) begin
                failures++;
                $display("FAIL %s_first_hold: got %0d cycles required 4", tag, commit_len_q[base]);
            end
        end
        checks++;
        if (done_samples != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_once: got done=%0d busy=%b required done=1 busy=0", tag, done_samples, busy);
        end
    endtask

    task automatic test_zero_voxels();
        int n, base, cycles, done_samples;
        logic rast_seen;
        n = 0; cycles = 0; done_samples = 0; rast_seen = 1'b0;
        voxel_count = '0;
        base = commit_addr_q.size();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_busy: got %b required 1", busy);
        end
        while (!do_shade && n < 50) begin
            if (do_rasterize) rast_seen = 1'b1;
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL zero_shade_latency: got %0d cycles required 3", n);
        end
        while (!done && cycles < 300) begin
            if (do_rasterize) rast_seen = 1'b1;
            @(posedge clock); #1;
            cycles++;
        end
        if (done) done_samples++;
        @(posedge clock); #1;
        if (done) done_samples++;
        checks++;
        if (rast_seen !== 1'b0) begin
            failures++;
            $display("FAIL zero_raster: got do_rasterize=1 required never");
        end
        checks++;
        if (done_samples != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: got done=%0d busy=%b required done=1 busy=0", done_samples, busy);
        end
        checks++;
        if (commit_addr_q.size() - base != 4) begin
            failures++;
            $display("FAIL zero_writes: got %0d required 4", commit_addr_q.size() - base);
        end
    endtask

    task automatic test_reset_mid_raster();
        int n;
        n = 0;
        voxel_count = 10'd3;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (!do_rasterize && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (do_rasterize !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reach_raster: got do_rasterize=%b required 1", do_rasterize);
        end
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({do_rasterize, do_shade, fb_we, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_ctrl: got %b required 00000", {do_rasterize, do_shade, fb_we, busy, done});
        end
        checks++;
        if ({vox_addr, pal_addr, voxel_x, voxel_y, voxel_z, voxel_id, palette_entry} !== '0) begin
            failures++;
            $display("FAIL midreset_data: got %h required 0",
                     {vox_addr, pal_addr, voxel_x, voxel_y, voxel_z, voxel_id, palette_entry});
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({fb_we, busy, do_rasterize} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_idle: got fb_we/busy/do_rasterize=%b required 000", {fb_we, busy, do_rasterize});
        end
    endtask

    initial begin
        test_reset();
        test_full_frame("frame");
        test_zero_voxels();
        test_reset_mid_raster();
        test_full_frame("after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): COORD_BITS, 8, voxel coordinate width; PALETTE_BITS, 8, voxel/palette id width; PIXEL_BITS, 8, palette colour width; VADDR_BITS, 10, voxel memory address width; ROWS, 4, shader array rows; COLS, 4, shader array columns; ROW_BITS, 8, row index width; COL_BITS, 8, column index width.
REQ-002 SHALL have ports (name direction width meaning): clock in 1 clock; reset in 1 asynchronous active-high reset; start in 1 begin frame; voxel_count in VADDR_BITS number of voxels; vox_addr out VADDR_BITS voxel memory address; vox_rdata in 3*COORD_BITS+PALETTE_BITS {x,y,z,id}, MSB first; pal_addr out PALETTE_BITS palette address; pal_rdata in PIXEL_BITS palette colour; do_rasterize out 1; do_shade out 1; voxel_x/voxel_y/voxel_z out COORD_BITS each; voxel_id out PALETTE_BITS; palette_entry out PIXEL_BITS; rasterizing_done in 1 AND of all shaders; shading_done in 1 AND of all shaders; row out ROW_BITS; col out COL_BITS; pixel in PIXEL_BITS shared shader bus; fb_we out 1; fb_addr out ROW_BITS+COL_BITS {row,col}; fb_data out PIXEL_BITS; fb_ready in 1; busy out 1; done out 1.

Function
REQ-003 SHALL implement states IDLE, PREFETCH, RASTER, SHADE, READOUT, READ_WAIT, WRITE, FINISH.
REQ-004 SHALL treat vox_rdata and pal_rdata as valid exactly one cycle after the address is driven.
REQ-005 IDLE: start=1 -> PREFETCH with vox_addr=0, voxel index counter=0; start ignored in all other states.
REQ-006 PREFETCH: 2 cycles; loads voxel 0 into voxel_x/y/z/id, drives vox_addr=1; then RASTER with do_rasterize=1. voxel_count=0 -> skip to SHADE setup (REQ-009).
REQ-007 RASTER: do_rasterize held 1 continuously; voxel outputs stable until rasterizing_done sampled 1; on that edge outputs load prefetched voxel i+1 and vox_addr advances to i+2, so shaders re-enter measurement with no gap or IDLE visit.
REQ-008 RASTER: when rasterizing_done sampled 1 for voxel index voxel_count-1 -> do_rasterize=0 on that edge; voxel outputs hold.
REQ-009 SHADE setup: pal_addr=0; one cycle later palette_entry=pal_rdata, voxel_id=0, do_shade=1.
REQ-010 SHADE: do_shade held 1; on each sampled shading_done, voxel_id increments, palette_entry loads colour of new id (pal_addr prefetched one ahead); after id 2^PALETTE_BITS-1 done -> do_shade=0, enter READOUT; id counter SHALL NOT wrap to 0 while do_shade=1.
REQ-011 READOUT: drives row/col, starting (0,0); READ_WAIT one cycle; then WRITE: fb_we=1, fb_addr={row,col}, fb_data=pixel sampled in READ_WAIT.
REQ-012 WRITE: fb_we, fb_addr, fb_data held until fb_ready=1; on that edge col increments; col=COLS-1 -> col=0, row+1; after (ROWS-1,COLS-1) -> FINISH.
REQ-013 FINISH: done=1 one cycle, then IDLE.
REQ-014 busy=1 in every state except IDLE.
REQ-015 row/col SHALL hold (ROWS-1,COLS-1)... no: row/col SHALL be 0 outside READOUT/READ_WAIT/WRITE.
REQ-016 Unexpected rasterizing_done/shading_done outside RASTER/SHADE SHALL be ignored.

Reset
REQ-017 Asynchronous reset SHALL force IDLE and all outputs to 0 (do_rasterize, do_shade, fb_we, busy, done, addresses, voxel fields, palette_entry, row, col, fb_data), including mid-frame; no memory/fb write SHALL occur in the cycle after reset deasserts.

Verification
REQ-018 voxel_count=3, voxel memory {(1,2,3,5),(4,4,4,7),(0,0,9,2)}, done pulsed 9 cycles after each voxel presented -> do_rasterize high without drop across all 3, voxel outputs change only on done edges, drop after third.
REQ-019 voxel_count=0 -> do_rasterize never asserts; do_shade asserts 3 cycles after start.
REQ-020 PALETTE_BITS=2, palette {10,20,30,40}, shading_done every 2nd cycle -> voxel_id/palette_entry sequence (0,10),(1,20),(2,30),(3,40), then do_shade=0.
REQ-021 ROWS=2, COLS=2, pixel bus returns row*16+col, fb_ready stalled 3 cycles on first write -> 4 writes to addresses {0,0},{0,1},{1,0},{1,1} with data 0,1,16,17; first write held 4 cycles; done pulses once.
REQ-022 reset asserted during RASTER -> same-cycle outputs 0, state IDLE; next start runs a full, correct frame.
REQ-023 start pulsed during READOUT -> ignored; exactly one done pulse.
